// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the MMIO UART transmitter: register word offsets,
// STATUS bit positions, FSM state encodings and the divisor clamp helper.
package mmio_uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_DROPS   = 2'd3;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // A programmed divisor of 0 would give zero-length bits; run it as 1.
    function automatic logic [15:0] eff_divisor(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Register-bus bundle for the UART: word address, write data, byte enables,
// read enable and registered read data.
//   master : drives addr/din/bwe/ren, samples dout
//   slave  : samples addr/din/bwe/ren, drives dout
interface mmio_uart_tx_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:2] addr;
    logic [31:0]           din;
    logic [3:0]            bwe;
    logic                  ren;
    logic [31:0]           dout;

    modport master (output addr, output din, output bwe, output ren, input dout);
    modport slave  (input addr, input din, input bwe, input ren, output dout);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous show-ahead FIFO used as the UART TX queue.
//   clk, resetn : clock, synchronous active-low reset
//   push, din   : enqueue request; accepted when not full, or when full and
//                 a pop happens in the same cycle
//   pop, dout   : dequeue request (ignored when empty); dout shows the head
//   count, full, empty : occupancy
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (resetn && do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter (8N1) with a TX FIFO.
//   clk, resetn : clock, synchronous active-low reset
//   bus         : register bus (slave); words TXDATA, STATUS, DIVISOR, DROPS
//   tx          : serial line, idle high
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for DIVISOR cycles
// DATA  | 8 data bits, LSB first, DIVISOR cycles each
// STOP  | stop bit (high); next byte follows with no gap if queued
import mmio_uart_tx_pkg::*;

module mmio_uart_tx #(
    parameter int ADDR_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           resetn,
    mmio_uart_tx_if.slave  bus,
    output logic           tx
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-3:0] A_TXDATA  = (ADDR_WIDTH-2)'(REG_TXDATA);
    localparam logic [ADDR_WIDTH-3:0] A_STATUS  = (ADDR_WIDTH-2)'(REG_STATUS);
    localparam logic [ADDR_WIDTH-3:0] A_DIVISOR = (ADDR_WIDTH-2)'(REG_DIVISOR);
    localparam logic [ADDR_WIDTH-3:0] A_DROPS   = (ADDR_WIDTH-2)'(REG_DROPS);

    logic          wr_en, push_req, pop, drop;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic [15:0]   divisor_q, divisor_d, div_eff;
    logic [7:0]    drops_q, drops_d;
    logic [31:0]   dout_q, dout_d, status;
    logic          unused_din;

    tx_state_e     state_q;
    logic [15:0]   cnt_q, div_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;

    assign wr_en      = |bus.bwe;
    assign push_req   = wr_en && (bus.addr == A_TXDATA) && bus.bwe[0];
    assign pop        = !fifo_empty &&
                        ((state_q == ST_IDLE) || ((state_q == ST_STOP) && (cnt_q == 16'd0)));
    assign drop       = push_req && fifo_full && !pop;
    assign div_eff    = eff_divisor(divisor_q);
    assign unused_din = ^bus.din[31:16];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_req),
        .pop    (pop),
        .din    (bus.din[7:0]),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        status = '0;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_FULL]  = fifo_full;
        status[STAT_BUSY]  = (state_q != ST_IDLE);
        status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
    end

    always_comb begin
        divisor_d = divisor_q;
        if (wr_en && (bus.addr == A_DIVISOR)) begin
            if (bus.bwe[0]) divisor_d[7:0]  = bus.din[7:0];
            if (bus.bwe[1]) divisor_d[15:8] = bus.din[15:8];
        end

        drops_d = drops_q;
        if (wr_en && (bus.addr == A_DROPS)) begin
            // A clear that coincides with a drop keeps that drop.
            drops_d = {7'd0, drop};
        end else if (drop && (drops_q != 8'hFF)) begin
            drops_d = drops_q + 8'd1;
        end

        dout_d = dout_q;
        if (bus.ren) begin
            case (bus.addr)
                A_STATUS:  dout_d = status;
                A_DIVISOR: dout_d = {16'd0, divisor_q};
                A_DROPS:   dout_d = {24'd0, drops_q};
                default:   dout_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            divisor_q <= 16'(CLKS_PER_BIT);
            drops_q   <= '0;
            dout_q    <= '0;
        end else begin
            divisor_q <= divisor_d;
            drops_q   <= drops_d;
            dout_q    <= dout_d;
        end
    end

    // The divisor is latched into div_q at every frame start so that
    // register writes mid-frame only affect the following frame.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= ST_START;
                        shift_q <= fifo_dout;
                        div_q   <= div_eff;
                        cnt_q   <= div_eff - 16'd1;
                        tx_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= ST_DATA;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        cnt_q   <= div_q - 16'd1;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q <= div_q - 16'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == 16'd0) begin
                        if (!fifo_empty) begin
                            state_q <= ST_START;
                            shift_q <= fifo_dout;
                            div_q   <= div_eff;
                            cnt_q   <= div_eff - 16'd1;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.dout = dout_q;
    assign tx       = tx_q;
endmodule
